alu_seq_exec: RTL and testbench
===============================

// Module: alu_seq_exec
// PURPOSE
//  Next-generation execute stage: merges ALU control decode (ALUOp/func3/func7) with a registered,
//  multi-cycle ALU datapath behind valid/ready handshakes. Decodes the full RV32I op set,
//  performs shifts iteratively and flags illegal encodings. Sits between ID/EX and EX/MEM.
// PARAMETERS
//  XLEN        32  datapath width; must be a power of 2, >= 8
//  SHIFT_STEP  4   bit positions shifted per cycle, 1..XLEN, power of 2
// PORTS
//  clk          in   1     clock, all state updates on rising edge
//  rst          in   1     synchronous, active-high reset
//  in_valid     in   1     operation presented
//  in_ready     out  1     unit accepts operation this cycle
//  alu_op       in   2     00 R-type, 01 I-type, 10 branch compare, 11 address (ld/st/jal)
//  func3        in   3     instruction func3
//  func7        in   7     instruction func7 (I-type: imm[11:5])
//  src_a        in   XLEN  operand A
//  src_b        in   XLEN  operand B / immediate; shamt = src_b[log2(XLEN)-1:0]
//  out_valid    out  1     result held
//  out_ready    in   1     consumer takes result
//  out_result   out  XLEN  result
//  out_zero     out  1     out_result == 0
//  out_lt       out  1     branch: signed (func3[1]=0) / unsigned (func3[1]=1) A<B; else 0
//  out_illegal  out  1     encoding not decodable; out_result forced to 0
//  busy         out  1     state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; out_valid, out_result, out_zero, out_lt, out_illegal, busy all 0; in_ready=1.
//  FSM IDLE -> EXEC (single-cycle op) | SHIFT (shift, shamt!=0) | MUL (ALU_MUL_EN) -> DONE.
//  Transfer on in_valid&in_ready: operands, decoded op, shamt captured; unit ignores inputs after.
//  in_ready = (state==IDLE) | (state==DONE & out_ready): back-to-back accept in same cycle result leaves.
//  Single-cycle ops and illegal: out_valid exactly 1 cycle after accept.
//  SHIFT: per cycle shift by min(SHIFT_STEP, remaining); latency = 1 + ceil(shamt/SHIFT_STEP);
//   shamt==0 -> latency 1, result = src_a. SRA fills with src_a[XLEN-1].
//  DONE: outputs stable while out_valid & !out_ready; leave on out_ready (to IDLE, or new op).
//  Decode R (00): f3 000 ADD/SUB(f7=0100000); 001 SLL; 010 SLT; 011 SLTU; 100 XOR;
//   101 SRL/SRA(f7=0100000); 110 OR; 111 AND. f7 must be 0000000, or 0100000 only with f3 000/101.
//  Decode I (01): as R but f3 000 always ADD; f7 checked only for f3 001 (=0) and 101 (0/0100000).
//  Decode B (10): SUB, out_lt per func3[1]; func3 010/011 illegal. Decode 11: ADD, func3 ignored.
//  Arithmetic: modulo 2^XLEN, no carry/overflow outputs; SLT/SLTU give 0 or 1 zero-extended.
//  rst mid-operation: aborts immediately, returns to reset values; no result emitted.
// CONFIGURATION
//  ALU_MUL_EN defined: R-type f7=0000001, f3=000 -> MUL, low XLEN bits of product, shift-add
//   1 bit/cycle, latency XLEN+1. Other f3 with f7=0000001 illegal.
//  ALU_MUL_EN undefined: any f7=0000001 encoding illegal (latency 1); MUL state absent.
// STRUCTURE
//  alu_pkg: ALUOp constants (ALUOP_R/I/B/ADDR), op enum (ALU_ADD..ALU_AND, ALU_MUL), FSM state enum.
//  Sub-module alu_op_decode: combinational alu_op/func3/func7 -> {op, illegal}; FSM/datapath here.
// TESTING
//  XLEN=32: R f3=000 f7=0100000, A=5,B=7 -> result 0xFFFFFFFE, zero=0, latency 1.
//  I SRAI A=0x80000000 shamt=9, SHIFT_STEP=4 -> 0xFFC00000 after 4 cycles; busy high during.
//  B f3=110 A=1,B=0xFFFFFFFF -> out_lt=1 (unsigned); f3=100 same operands -> out_lt=0.
//  R f3=001 f7=0100000 -> out_illegal=1, result 0, latency 1; hold out_ready=0 3 cycles -> outputs stable.
//  Back-to-back ADDs with out_ready=1 -> one result/cycle after first; rst during SHIFT -> out_valid stays 0.
//  ALU_MUL_EN: A=0xFFFF,B=0x10001 -> 0xFFFFFFFF after 33 cycles; without macro -> illegal.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALUOp constants, operation and FSM state encodings for the execute stage.
// ALU_MUL_EN adds the MUL state used by the shift-add multiplier.
package alu_pkg;

    localparam logic [1:0] ALUOP_R    = 2'b00;
    localparam logic [1:0] ALUOP_I    = 2'b01;
    localparam logic [1:0] ALUOP_B    = 2'b10;
    localparam logic [1:0] ALUOP_ADDR = 2'b11;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL
    } alu_op_e;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL, ST_DONE} state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;
`endif

    function automatic logic is_shift(alu_op_e op);
        return op inside {ALU_SLL, ALU_SRL, ALU_SRA};
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU control: alu_op/func3/func7 -> operation and illegal flag.
// MUL encodings decode only when ALU_MUL_EN is defined.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output alu_op_e    op,
    output logic       illegal
);

    alu_op_e base;

    always_comb begin
        base = ALU_ADD;
        unique case (func3)
            3'b000:  base = ALU_ADD;
            3'b001:  base = ALU_SLL;
            3'b010:  base = ALU_SLT;
            3'b011:  base = ALU_SLTU;
            3'b100:  base = ALU_XOR;
            3'b101:  base = ALU_SRL;
            3'b110:  base = ALU_OR;
            default: base = ALU_AND;
        endcase
    end

    always_comb begin
        op      = base;
        illegal = 1'b0;
        unique case (alu_op)
            ALUOP_R: begin
                if (func7 == F7_ALT && func3 == 3'b000)
                    op = ALU_SUB;
                else if (func7 == F7_ALT && func3 == 3'b101)
                    op = ALU_SRA;
`ifdef ALU_MUL_EN
                else if (func7 == F7_MUL && func3 == 3'b000)
                    op = ALU_MUL;
`endif
                else if (func7 != F7_BASE)
                    illegal = 1'b1;
            end
            ALUOP_I: begin
                // Immediate high bits only matter where they encode shift type.
                if (func3 == 3'b001)
                    illegal = (func7 != F7_BASE);
                else if (func3 == 3'b101) begin
                    if (func7 == F7_ALT)
                        op = ALU_SRA;
                    else
                        illegal = (func7 != F7_BASE);
                end
            end
            ALUOP_B: begin
                op      = ALU_SUB;
                illegal = (func3[2:1] == 2'b01);
            end
            default: op = ALU_ADD;
        endcase
        if (illegal)
            op = ALU_ADD;
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Multi-cycle execute stage: iterative shifter behind valid/ready handshakes.
// ALU_MUL_EN enables a 1-bit-per-cycle shift-add multiplier.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic            out_lt,
    output logic            out_illegal,
    output logic            busy
);

    localparam int SW = $clog2(XLEN);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

    state_e          state;
    alu_op_e         op_q;
    alu_op_e         dec_op;
    logic            dec_ill;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] fast;
    logic [XLEN-1:0] shifted;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   step;
    logic [SW-1:0]   shamt;
    logic            accept;
    logic            lt_v;

    alu_op_decode u_dec (
        .alu_op  (alu_op),
        .func3   (func3),
        .func7   (func7),
        .op      (dec_op),
        .illegal (dec_ill)
    );

    assign shamt     = src_b[SW-1:0];
    assign in_ready  = (state == ST_IDLE) || (state == ST_DONE && out_ready);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign step      = (cnt > STEP) ? STEP : cnt;

    always_comb begin
        lt_v = 1'b0;
        if (alu_op == ALUOP_B && !dec_ill)
            lt_v = func3[1] ? (src_a < src_b)
                            : ($signed(src_a) < $signed(src_b));
    end

    // Shifts land here only with shamt == 0, so passing src_a through is exact.
    always_comb begin
        fast = src_a;
        unique case (dec_op)
            ALU_ADD:  fast = src_a + src_b;
            ALU_SUB:  fast = src_a - src_b;
            ALU_SLT:  fast = XLEN'($signed(src_a) < $signed(src_b));
            ALU_SLTU: fast = XLEN'(src_a < src_b);
            ALU_XOR:  fast = src_a ^ src_b;
            ALU_OR:   fast = src_a | src_b;
            ALU_AND:  fast = src_a & src_b;
            default:  fast = src_a;
        endcase
    end

    always_comb begin
        shifted = acc;
        unique case (op_q)
            ALU_SLL: shifted = acc << step;
            ALU_SRA: shifted = XLEN'($signed(acc) >>> step);
            default: shifted = acc >> step;
        endcase
    end

`ifdef ALU_MUL_EN
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] mul_sum;
    assign mul_sum = out_result + (opb[0] ? acc : '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_q        <= ALU_ADD;
            acc         <= '0;
            cnt         <= '0;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_lt      <= 1'b0;
            out_illegal <= 1'b0;
`ifdef ALU_MUL_EN
            opb         <= '0;
`endif
        end else if (accept) begin
            op_q        <= dec_op;
            acc         <= src_a;
            out_illegal <= dec_ill;
            out_lt      <= lt_v;
`ifdef ALU_MUL_EN
            opb         <= src_b;
`endif
            if (dec_ill) begin
                out_result <= '0;
                out_zero   <= 1'b1;
                state      <= ST_DONE;
            end else if (is_shift(dec_op) && shamt != '0) begin
                cnt   <= CW'(shamt);
                state <= ST_SHIFT;
            end
`ifdef ALU_MUL_EN
            else if (dec_op == ALU_MUL) begin
                cnt        <= CW'(XLEN);
                out_result <= '0;
                state      <= ST_MUL;
            end
`endif
            else begin
                out_result <= fast;
                out_zero   <= (fast == '0);
                state      <= ST_DONE;
            end
        end else begin
            unique case (state)
                ST_SHIFT: begin
                    acc <= shifted;
                    cnt <= cnt - step;
                    if (cnt == step) begin
                        out_result <= shifted;
                        out_zero   <= (shifted == '0);
                        state      <= ST_DONE;
                    end
                end
`ifdef ALU_MUL_EN
                ST_MUL: begin
                    out_result <= mul_sum;
                    acc        <= acc << 1;
                    opb        <= opb >> 1;
                    cnt        <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        out_zero <= (mul_sum == '0);
                        state    <= ST_DONE;
                    end
                end
`endif
                ST_DONE: if (out_ready) state <= ST_IDLE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Scoreboard bench for alu_seq_exec: directed encodings, latency, hold, reset abort, random ops.
// Expected MUL behaviour follows ALU_MUL_EN.
module tb_alu_seq_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_lt;
    logic        out_illegal;
    logic        busy;

    always #5 clk = ~clk;

    alu_seq_exec #(.XLEN(32), .SHIFT_STEP(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_op      (alu_op),
        .func3       (func3),
        .func7       (func7),
        .src_a       (src_a),
        .src_b       (src_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_lt      (out_lt),
        .out_illegal (out_illegal),
        .busy        (busy)
    );

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        lt;
        logic        ill;
        int          lat;
        int          acyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   seen = 0;
    int   first = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(logic [1:0] op, logic [2:0] f3, logic [6:0] f7,
                                   logic [31:0] a, logic [31:0] b);
        exp_t        e;
        int          sh;
        logic        legal;
        logic        alt;
        logic        shift;
        logic        ismul;
        logic [31:0] res;
        sh    = int'(b[4:0]);
        legal = 1'b1;
        alt   = 1'b0;
        shift = 1'b0;
        ismul = 1'b0;
        res   = 32'h0;
        e.lt  = 1'b0;
        e.lat = 1;
        e.acyc = 0;
        if (op == 2'b00) begin
            alt = (f7 == 7'h20);
            if (f7 == 7'h20)
                legal = (f3 == 3'd0 || f3 == 3'd5);
            else if (f7 == 7'h01) begin
`ifdef ALU_MUL_EN
                legal = (f3 == 3'd0);
                ismul = legal;
`else
                legal = 1'b0;
`endif
            end else if (f7 != 7'h00)
                legal = 1'b0;
        end else if (op == 2'b01) begin
            alt   = (f3 == 3'd5 && f7 == 7'h20);
            legal = !((f3 == 3'd1 && f7 != 7'h00) ||
                      (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20));
        end
        if (op[1] == 1'b0) begin
            case (f3)
                3'd0: res = (op == 2'b00 && alt) ? a - b : a + b;
                3'd1: begin res = a << sh; shift = 1'b1; end
                3'd2: res = {31'h0, $signed(a) < $signed(b)};
                3'd3: res = {31'h0, a < b};
                3'd4: res = a ^ b;
                3'd5: begin
                    res   = alt ? 32'($signed(a) >>> sh) : a >> sh;
                    shift = 1'b1;
                end
                3'd6: res = a | b;
                default: res = a & b;
            endcase
        end else if (op == 2'b10) begin
            legal = !(f3 == 3'd2 || f3 == 3'd3);
            res   = a - b;
            e.lt  = f3[1] ? (a < b) : ($signed(a) < $signed(b));
        end else
            res = a + b;
        if (ismul) begin
            res   = a * b;
            e.lat = 33;
        end
        if (shift && sh != 0)
            e.lat = 1 + (sh + 3) / 4;
        if (!legal) begin
            res   = 32'h0;
            e.lt  = 1'b0;
            e.lat = 1;
        end
        e.res  = res;
        e.zero = (res == 32'h0);
        e.ill  = !legal;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            seen = 0;
        end else begin
            if (out_valid && !seen) begin
                seen  = 1;
                first = cyc;
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0)
                    chk("unexpected_out", 32'd1, 32'd0);
                else begin
                    mon_e = sbq.pop_front();
                    chk("result", out_result, mon_e.res);
                    chk("zero", 32'(out_zero), 32'(mon_e.zero));
                    chk("lt", 32'(out_lt), 32'(mon_e.lt));
                    chk("illegal", 32'(out_illegal), 32'(mon_e.ill));
                    chk("latency", 32'(first - mon_e.acyc), 32'(mon_e.lat));
                end
                seen = 0;
            end
            if (in_valid && in_ready) begin
                mon_e      = model(alu_op, func3, func7, src_a, src_b);
                mon_e.acyc = cyc;
                sbq.push_back(mon_e);
            end
        end
    end

    task automatic send(logic [1:0] op, logic [2:0] f3, logic [6:0] f7,
                        logic [31:0] a, logic [31:0] b);
        bit ok;
        ok       = 0;
        alu_op   = op;
        func3    = f3;
        func7    = f7;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok)
            chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            if (sbq.size() == 0)
                break;
            @(posedge clk);
        end
        chk("drain_empty", 32'(sbq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int start;
        logic [6:0] f7r;
        rst       = 1'b1;
        in_valid  = 1'b0;
        alu_op    = 2'b00;
        func3     = 3'b000;
        func7     = 7'h00;
        src_a     = 32'h0;
        src_b     = 32'h0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_flags", {29'h0, out_zero, out_lt, out_illegal}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        send(2'b00, 3'b000, 7'h20, 32'd5, 32'd7);
        drain();

        send(2'b01, 3'b101, 7'h20, 32'h8000_0000, 32'd9);
        @(negedge clk);
        chk("busy_shift0", 32'(busy), 32'd1);
        @(negedge clk);
        chk("busy_shift1", 32'(busy), 32'd1);
        drain();

        send(2'b01, 3'b001, 7'h00, 32'h0000_ABCD, 32'd32);
        send(2'b00, 3'b001, 7'h00, 32'h0000_0003, 32'd4);
        send(2'b00, 3'b101, 7'h00, 32'hF000_0000, 32'd31);
        send(2'b00, 3'b101, 7'h20, 32'hF000_0000, 32'd31);
        drain();

        send(2'b10, 3'b110, 7'h00, 32'd1, 32'hFFFF_FFFF);
        send(2'b10, 3'b100, 7'h00, 32'd1, 32'hFFFF_FFFF);
        send(2'b10, 3'b010, 7'h00, 32'd1, 32'd2);
        send(2'b11, 3'b111, 7'h55, 32'h1000, 32'h0FFF_F000);
        send(2'b00, 3'b011, 7'h00, 32'd5, 32'd5);
        drain();

        out_ready = 1'b0;
        send(2'b00, 3'b001, 7'h20, 32'd3, 32'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", out_result, 32'd0);
            chk("hold_flags", {29'h0, out_zero, out_lt, out_illegal}, 32'd5);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        start = cyc;
        for (int i = 0; i < 4; i++)
            send(2'b00, 3'b000, 7'h00, 32'(i * 100 + 1), 32'(i));
        chk("b2b_cycles", 32'(cyc - start), 32'd4);
        drain();

        send(2'b01, 3'b001, 7'h00, 32'h1234, 32'd28);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_valid", 32'(out_valid), 32'd0);
        end
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        send(2'b00, 3'b000, 7'h01, 32'h0000_FFFF, 32'h0001_0001);
        send(2'b00, 3'b011, 7'h01, 32'd6, 32'd7);
        drain();

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: f7r = 7'h00;
                1: f7r = 7'h20;
                2: f7r = 7'h01;
                default: f7r = 7'($urandom);
            endcase
            send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), f7r,
                 $urandom, ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
